// File: rtl/spram_pkg.sv
// Shared constants, bank state type and byte-mask helper for the SPRAM bank controller.
// Optional build macro: SPRAM_SLEEP_EN (per-bank idle sleep / wake sequencing).
package spram_pkg;

    localparam int unsigned BANK_AW     = 14;             // 16K words per SPRAM macro
    localparam int unsigned SPRAM_DW    = 16;             // SPRAM word width
    localparam int unsigned MASK_W      = 4;              // MASKWREN width (one bit per nibble)
    localparam int unsigned SPRAM_WORDS = 1 << BANK_AW;

    typedef enum logic [1:0] {
        StActive,
        StSleep,
        StWake
    } bank_state_e;

    // Byte enables to the SPRAM nibble mask: be[0] -> MASKWREN[1:0], be[1] -> MASKWREN[3:2].
    function automatic logic [MASK_W-1:0] be_to_mask(input logic [1:0] be);
        return {be[1], be[1], be[0], be[0]};
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP SB_SPRAM256KA macro (16K x 16, nibble write mask,
// registered read). Leave this file out of the iCE40 synthesis file list; the vendor
// cell library provides the real primitive there.
module SB_SPRAM256KA
    import spram_pkg::*;
(
    input  logic [BANK_AW-1:0]  ADDRESS,
    input  logic [SPRAM_DW-1:0] DATAIN,
    input  logic [MASK_W-1:0]   MASKWREN,
    input  logic                WREN,
    input  logic                CHIPSELECT,
    input  logic                CLOCK,
    input  logic                STANDBY,
    input  logic                SLEEP,
    input  logic                POWEROFF,
    output logic [SPRAM_DW-1:0] DATAOUT
);

    logic [SPRAM_DW-1:0] mem [SPRAM_WORDS];
    logic                en;

    // POWEROFF is active-low on this macro.
    assign en = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

    // Masked nibble writes; reads update DATAOUT, writes leave it unchanged.
    always_ff @(posedge CLOCK) begin
        if (en) begin
            if (WREN) begin
                for (int n = 0; n < MASK_W; n++) begin
                    if (MASKWREN[n]) begin
                        mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
                    end
                end
            end else begin
                DATAOUT <= mem[ADDRESS];
            end
        end
    end

endmodule

// File: rtl/spram_bank.sv
// One SPRAM bank: the SB_SPRAM256KA macro, its byte-mask mapping and, when built with
// SPRAM_SLEEP_EN, an idle/wake FSM that drives the SLEEP pin and gates bank readiness.
module spram_bank
    import spram_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned WAKE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BANK_AW-1:0]  addr,
    input  logic [SPRAM_DW-1:0] wdata,
    input  logic [1:0]          be,
    input  logic                we,       // accepted write to this bank
    input  logic                access,   // accepted request (read or write) to this bank
    input  logic                req_hit,  // pending request targets this bank
    output logic [SPRAM_DW-1:0] rdata,
    output logic                active    // bank can accept a request this cycle
);

    logic sleep;

`ifdef SPRAM_SLEEP_EN
    localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned WAKE_LD = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;

    bank_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bank power state and shared idle/wake counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StActive;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Idle counting, sleep entry and wake sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        active  = 1'b0;
        sleep   = 1'b0;
        unique case (state_q)
            StActive: begin
                active = 1'b1;
                if (access) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(IDLE_CYCLES - 1)) begin
                    state_d = StSleep;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSleep: begin
                // Release SLEEP in the same cycle the request shows up; that cycle counts
                // as the first wake cycle.
                sleep = ~req_hit;
                if (req_hit) begin
                    state_d = StWake;
                    cnt_d   = CW'(WAKE_LD);
                end
            end
            StWake: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StActive;
                cnt_d   = '0;
            end
        endcase
    end
`else
    logic unused_sig;

    assign active     = 1'b1;
    assign sleep      = 1'b0;
    assign unused_sig = ^{IDLE_CYCLES, WAKE_CYCLES, access, req_hit, reset_n};
`endif

    SB_SPRAM256KA u_spram (
        .ADDRESS    (addr),
        .DATAIN     (wdata),
        .MASKWREN   (be_to_mask(be)),
        .WREN       (we),
        .CHIPSELECT (1'b1),
        .CLOCK      (clk),
        .STANDBY    (1'b0),
        .SLEEP      (sleep),
        .POWEROFF   (1'b1),
        .DATAOUT    (rdata)
    );

endmodule

// File: rtl/spram_bank_ctrl.sv
// Linear word-addressed RAM built from NUM_BANKS SPRAM macros with a valid/ready request
// port, byte enables, a one-cycle registered read path and out-of-range detection.
// Optional build macro: SPRAM_SLEEP_EN (banks sleep when idle; req_ready waits for wake).
module spram_bank_ctrl
    import spram_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned AW          = BANK_AW + $clog2(NUM_BANKS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AW-1:0]       req_addr,
    input  logic [SPRAM_DW-1:0] req_wdata,
    input  logic [1:0]          req_be,
    output logic                rd_valid,
    output logic [SPRAM_DW-1:0] rd_data,
    output logic                err_oob
);

    // Bank index width; kept at least 1 so a single-bank build still has a legal vector.
    localparam int unsigned BSW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [BSW-1:0]      req_bank;
    logic                req_oob;
    logic                accept;
    logic                tgt_active;
    logic                ready_q;
    logic                rd_pend_q;
    logic                rd_oob_q;
    logic                err_q;
    logic [BSW-1:0]      rd_bank_q;
    logic [SPRAM_DW-1:0] rd_hold_q;
    logic [SPRAM_DW-1:0] bank_sel_data;
    logic [SPRAM_DW-1:0] rd_mux;
    logic [SPRAM_DW-1:0] bank_rdata [NUM_BANKS];
    logic                bank_active [NUM_BANKS];

    if (NUM_BANKS > 1) begin : g_multi
        assign req_bank = req_addr[AW-1:BANK_AW];
        assign req_oob  = (32'(req_bank) >= NUM_BANKS);
    end else begin : g_single
        assign req_bank = '0;
        assign req_oob  = 1'b0;
    end

    // Out-of-range targets have no bank to wait for, so they count as ready.
    always_comb begin
        tgt_active = req_oob;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (req_bank == BSW'(b)) begin
                tgt_active = bank_active[b];
            end
        end
    end

    // Gating with reset_n keeps a request from being taken (and a write from landing)
    // during a reset cycle.
    assign req_ready = ready_q & reset_n & tgt_active;
    assign accept    = req_valid & req_ready;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel;

        assign sel = (req_bank == BSW'(b)) & ~req_oob;

        spram_bank #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .addr    (req_addr[BANK_AW-1:0]),
            .wdata   (req_wdata),
            .be      (req_be),
            .we      (accept & req_we & sel),
            .access  (accept & sel),
            .req_hit (req_valid & sel),
            .rdata   (bank_rdata[b]),
            .active  (bank_active[b])
        );
    end

    // Select read data by the bank registered at accept, not the live address.
    always_comb begin
        bank_sel_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_q == BSW'(b)) begin
                bank_sel_data = bank_rdata[b];
            end
        end
    end

    assign rd_mux   = rd_oob_q ? '0 : bank_sel_data;
    assign rd_valid = rd_pend_q;
    assign rd_data  = rd_pend_q ? rd_mux : rd_hold_q;
    assign err_oob  = err_q;

    // Handshake, read-tracking and output hold registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_oob_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_bank_q <= '0;
            rd_hold_q <= '0;
        end else begin
            ready_q   <= 1'b1;
            rd_pend_q <= accept & ~req_we;
            rd_oob_q  <= accept & ~req_we & req_oob;
            err_q     <= accept & req_oob;
            if (accept) begin
                rd_bank_q <= req_bank;
            end
            if (rd_pend_q) begin
                rd_hold_q <= rd_mux;
            end
        end
    end

endmodule
